// File: rtl/apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter
//
// Purpose
//   Shares one APB master port between NUM_REQ requesters. A round-robin
//   arbiter picks one pending request while the bus is idle and captures its
//   payload. The transfer then runs as a standard SETUP/ACCESS APB cycle.
//   The result is returned as a one-cycle response pulse to the owner.
//   A watchdog aborts an ACCESS phase that waits too long for b_pready.
//
// Ports
//   b_pclk, b_prst_n       clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester request and one-hot accept pulse
//   req_write/addr/wdata/  per-requester payload, packed with requester i at
//   req_prot/req_strb      [i*W +: W]
//   rsp_valid              one-hot completion pulse
//   rsp_rdata, rsp_err     read data (held until next completion) and error
//   b_psel .. b_pstrb      APB master outputs (all registered)
//   b_prdata, b_pready,    APB slave responses
//   b_pslverr
// -----------------------------------------------------------------------------
module apb_master_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADDR_WD     = 32,
    parameter int unsigned DATA_WD     = 32,
    parameter int unsigned STRB_WD     = 4,
    parameter int unsigned PROT_WD     = 3,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                       b_pclk,
    input  logic                       b_prst_n,
    // requester side
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*ADDR_WD-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WD-1:0] req_wdata,
    input  logic [NUM_REQ*PROT_WD-1:0] req_prot,
    input  logic [NUM_REQ*STRB_WD-1:0] req_strb,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_WD-1:0]         rsp_rdata,
    output logic                       rsp_err,
    // APB side
    output logic                       b_psel,
    output logic                       b_penable,
    output logic                       b_pwrite,
    output logic [ADDR_WD-1:0]         b_paddr,
    output logic [DATA_WD-1:0]         b_pwdata,
    output logic [PROT_WD-1:0]         b_pprot,
    output logic [STRB_WD-1:0]         b_pstrb,
    input  logic [DATA_WD-1:0]         b_prdata,
    input  logic                       b_pready,
    input  logic                       b_pslverr
);

    localparam int unsigned GntW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [GntW-1:0] GntLast = GntW'(NUM_REQ - 1);
    // Abort fires on the ACCESS cycle in which the count would reach TIMEOUT_CYC.
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } state_e;

    state_e                state_q, state_d;
    // Doubles as last_grant: it stays valid after the transfer ends.
    logic [GntW-1:0]       grant_q, grant_d;
    logic [TmoW-1:0]       tmo_q, tmo_d;

    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WD-1:0]    paddr_q, paddr_d;
    logic [DATA_WD-1:0]    pwdata_q, pwdata_d;
    logic [PROT_WD-1:0]    pprot_q, pprot_d;
    logic [STRB_WD-1:0]    pstrb_q, pstrb_d;

    logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_WD-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    // -------------------------------------------------------------------------
    // Round-robin winner: first valid requester after the last grant.
    // -------------------------------------------------------------------------
    logic                  win_found;
    logic [GntW-1:0]       win_idx;
    logic [GntW-1:0]       cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = GntW'((32'(grant_q) + k) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and registered-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        tmo_d       = tmo_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pprot_d     = pprot_q;
        pstrb_d     = pstrb_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d              = StSetup;
                    grant_d              = win_idx;
                    tmo_d                = '0;
                    req_ready_d[win_idx] = 1'b1;
                    psel_d               = 1'b1;
                    penable_d            = 1'b0;
                    pwrite_d             = req_write[win_idx];
                    paddr_d              = req_addr[win_idx*ADDR_WD +: ADDR_WD];
                    pwdata_d             = req_wdata[win_idx*DATA_WD +: DATA_WD];
                    pprot_d              = req_prot[win_idx*PROT_WD +: PROT_WD];
                    pstrb_d              = req_strb[win_idx*STRB_WD +: STRB_WD];
                end
            end

            StSetup: begin
                state_d   = StAccess;
                penable_d = 1'b1;
            end

            StAccess: begin
                // b_pready wins over a timeout landing in the same cycle.
                if (b_pready) begin
                    state_d              = StIdle;
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_err_d            = b_pslverr;
                    rsp_rdata_d          = pwrite_q ? '0 : b_prdata;
                end else if (tmo_q == TmoLast) begin
                    state_d              = StIdle;
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_err_d            = 1'b1;
                    rsp_rdata_d          = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            default: begin
                state_d   = StIdle;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge b_pclk or negedge b_prst_n) begin
        if (!b_prst_n) begin
            state_q     <= StIdle;
            grant_q     <= GntLast;
            tmo_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pprot_q     <= '0;
            pstrb_q     <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            tmo_q       <= tmo_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pprot_q     <= pprot_d;
            pstrb_q     <= pstrb_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign b_psel    = psel_q;
    assign b_penable = penable_q;
    assign b_pwrite  = pwrite_q;
    assign b_paddr   = paddr_q;
    assign b_pwdata  = pwdata_q;
    assign b_pprot   = pprot_q;
    assign b_pstrb   = pstrb_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_master_arbiter
//
// Random requesters and a random-latency APB slave drive the arbiter. A
// transaction-level model predicts, for each grant, the requester index, the
// bus window and the response. Predictions go into queues that a separate
// negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_apb_master_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = 4;
    localparam int unsigned PW  = 3;
    localparam int unsigned TMO = 4;

    logic              b_pclk = 1'b0;
    logic              b_prst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N*PW-1:0]   req_prot;
    logic [N*SW-1:0]   req_strb;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              b_psel, b_penable, b_pwrite;
    logic [AW-1:0]     b_paddr;
    logic [DW-1:0]     b_pwdata;
    logic [PW-1:0]     b_pprot;
    logic [SW-1:0]     b_pstrb;
    logic [DW-1:0]     b_prdata;
    logic              b_pready;
    logic              b_pslverr;

    apb_master_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WD    (AW),
        .DATA_WD    (DW),
        .STRB_WD    (SW),
        .PROT_WD    (PW),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .b_pclk   (b_pclk),
        .b_prst_n (b_prst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_prot (req_prot),
        .req_strb (req_strb),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .b_psel   (b_psel),
        .b_penable(b_penable),
        .b_pwrite (b_pwrite),
        .b_paddr  (b_paddr),
        .b_pwdata (b_pwdata),
        .b_pprot  (b_pprot),
        .b_pstrb  (b_pstrb),
        .b_prdata (b_prdata),
        .b_pready (b_pready),
        .b_pslverr(b_pslverr)
    );

    always #5 b_pclk = ~b_pclk;

    // Cycle n is the interval following the n-th rising edge.
    int cyc = 0;
    always @(posedge b_pclk) cyc <= cyc + 1;

    typedef struct { int cyc; int idx; } rdy_t;
    typedef struct { int s; int a; logic [71:0] pay; } bus_t;
    typedef struct { int cyc; int idx; logic err; logic [31:0] rdata; } rsp_t;

    rdy_t rdy_q[$];
    bus_t bus_q[$];
    rsp_t rsp_q[$];

    // Requester and model state (written only by the stimulus process)
    logic [N-1:0] pending = '0;
    logic         p_wr    [N];
    logic [31:0]  p_addr  [N];
    logic [31:0]  p_wdata [N];
    logic [2:0]   p_prot  [N];
    logic [3:0]   p_strb  [N];
    int           last_m     = N - 1;
    int           free_cyc   = 0;
    int           pready_cyc = -1;
    logic [31:0]  exp_prdata = '0;
    logic         exp_slverr = 1'b0;
    bit           run = 0, force_all = 0, force_w0 = 0, long_next = 0;
    bit           done = 0, drain_to = 0;

    // Scoreboard counters (written only by the monitor)
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [31:0]  hold_rdata = '0;

    task automatic step(output bit granted);
        int   w;
        int   wt;
        int   a;
        bit   to;
        rdy_t r;
        bus_t b;
        rsp_t p;
        granted = 0;
        // Requesters drop after their accept pulse, then may post a new request.
        for (int i = 0; i < N; i++)
            if (pending[i] && req_ready[i]) pending[i] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!pending[i] && (force_all || (run && $urandom_range(0, 3) == 0))) begin
                pending[i] = 1'b1;
                p_wr[i]    = 1'($urandom_range(0, 1));
                p_addr[i]  = $urandom;
                p_wdata[i] = $urandom;
                p_prot[i]  = 3'($urandom);
                p_strb[i]  = 4'($urandom);
            end
        end
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = pending[i];
            req_write[i]           = p_wr[i];
            req_addr[i*AW +: AW]   = p_addr[i];
            req_wdata[i*DW +: DW]  = p_wdata[i];
            req_prot[i*PW +: PW]   = p_prot[i];
            req_strb[i*SW +: SW]   = p_strb[i];
        end
        // Bus free and someone waiting: next round-robin requester wins.
        if (b_prst_n && cyc >= free_cyc && pending != '0) begin
            w = -1;
            for (int k = 1; k <= N; k++)
                if (w < 0 && pending[(last_m + k) % N]) w = (last_m + k) % N;
            last_m = w;
            if (long_next)     wt = TMO + 2;
            else if (force_w0) wt = 0;
            else               wt = $urandom_range(0, TMO + 2);
            long_next  = 0;
            to         = (wt + 1 > TMO);
            a          = to ? TMO : wt + 1;
            exp_prdata = $urandom;
            exp_slverr = force_w0 ? 1'b0 : 1'($urandom_range(0, 1));
            r.cyc = cyc + 1;
            r.idx = w;
            rdy_q.push_back(r);
            b.s   = cyc + 1;
            b.a   = a;
            b.pay = {p_wr[w], p_addr[w], p_wdata[w], p_prot[w], p_strb[w]};
            bus_q.push_back(b);
            p.cyc   = cyc + 2 + a;
            p.idx   = w;
            p.err   = to ? 1'b1 : exp_slverr;
            p.rdata = (to || p_wr[w]) ? 32'h0 : exp_prdata;
            rsp_q.push_back(p);
            pready_cyc = to ? -1 : cyc + 1 + a;
            free_cyc   = cyc + 2 + a;
            granted    = 1;
        end
        // Slave: ready only on the chosen cycle, noise on the data lines otherwise.
        if (b_prst_n && cyc == pready_cyc) begin
            b_pready  = 1'b1;
            b_prdata  = exp_prdata;
            b_pslverr = exp_slverr;
        end else begin
            b_pready  = 1'b0;
            b_prdata  = $urandom;
            b_pslverr = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    // Monitor
    always @(negedge b_pclk) begin
        logic [N-1:0] er;
        if (!b_prst_n) begin
            hold_rdata = '0;
            chk("reset_outputs",
                {req_ready, rsp_valid, rsp_rdata, rsp_err, b_psel, b_penable, b_pwrite,
                 b_paddr, b_pwdata, b_pprot, b_pstrb}, '0);
        end else begin
            er = '0;
            if (rdy_q.size() > 0 && rdy_q[0].cyc == cyc) begin
                er[rdy_q[0].idx] = 1'b1;
                void'(rdy_q.pop_front());
            end
            if (er != '0 || req_ready != '0) chk("req_ready", req_ready, er);

            while (bus_q.size() > 0 && cyc > bus_q[0].s + bus_q[0].a) void'(bus_q.pop_front());
            if (bus_q.size() > 0 && cyc >= bus_q[0].s) begin
                chk("psel_penable", {b_psel, b_penable}, {1'b1, cyc > bus_q[0].s});
                chk("apb_payload", {b_pwrite, b_paddr, b_pwdata, b_pprot, b_pstrb},
                    bus_q[0].pay);
            end else begin
                chk("bus_idle", {b_psel, b_penable}, 2'b00);
            end

            if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
                er = '0;
                er[rsp_q[0].idx] = 1'b1;
                chk("rsp_valid", rsp_valid, er);
                chk("rsp_err", rsp_err, rsp_q[0].err);
                hold_rdata = rsp_q[0].rdata;
                void'(rsp_q.pop_front());
            end else if (rsp_valid != '0) begin
                chk("rsp_valid_spurious", rsp_valid, '0);
            end
            chk("rsp_rdata", rsp_rdata, hold_rdata);
        end
        if (done) begin
            chk("queues_drained", rdy_q.size() + bus_q.size() + rsp_q.size(), 0);
            chk("drain_bound", drain_to, 0);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    // Stimulus
    initial begin
        bit g;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        req_prot  = '0; req_strb  = '0;
        b_prdata  = '0; b_pready  = 1'b0; b_pslverr = 1'b0;
        for (int i = 0; i < N; i++) begin
            p_wr[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0; p_prot[i] = '0; p_strb[i] = '0;
        end
        b_prst_n = 1'b1;
        #1 b_prst_n = 1'b0;
        repeat (3) @(negedge b_pclk);

        // All requesters busy, zero-wait slave: strict 0,1,2,3,0 rotation.
        force_all = 1; force_w0 = 1;
        b_prst_n  = 1'b1;
        free_cyc  = cyc;
        step(g);
        repeat (20) begin @(negedge b_pclk); step(g); end

        // Random traffic, waits and timeouts.
        force_all = 0; force_w0 = 0; run = 1;
        repeat (1500) begin @(negedge b_pclk); step(g); end

        // Reset in the middle of an ACCESS phase.
        long_next = 1;
        g = 0;
        for (int i = 0; i < 200 && !g; i++) begin @(negedge b_pclk); step(g); end
        if (!g) begin
            drain_to = 1;
        end else begin
            @(negedge b_pclk); step(g);
            @(posedge b_pclk); #2;
            b_prst_n = 1'b0;
            b_pready = 1'b0;
            rdy_q.delete(); bus_q.delete(); rsp_q.delete();
            pready_cyc = -1;
            last_m     = N - 1;
            force_all  = 1; force_w0 = 1; run = 0;
            repeat (3) begin @(negedge b_pclk); step(g); end
            @(negedge b_pclk);
            b_prst_n = 1'b1;
            free_cyc = cyc;
            step(g);
            repeat (12) begin @(negedge b_pclk); step(g); end
            force_all = 0; force_w0 = 0; run = 1;
            repeat (500) begin @(negedge b_pclk); step(g); end
        end

        // Drain outstanding requests with a bounded wait.
        run = 0;
        g = 0;
        for (int i = 0; i < 400 && !g; i++) begin
            @(negedge b_pclk);
            step(g);
            g = (pending == '0 && cyc > free_cyc);
        end
        if (!g) drain_to = 1;
        done = 1;
        repeat (5) @(negedge b_pclk);
        $display("FAIL monitor_stalled cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "monitor did not finish");
    end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_REQ, 4, number of requester ports (2..8)
- ADDR_WD, 32, APB address width
- DATA_WD, 32, APB data width
- STRB_WD, 4, APB strobe width
- PROT_WD, 3, APB protection width
- TIMEOUT_CYC, 255, maximum ACCESS cycles without b_pready (1..65535)
REQ-002 Clock and reset: b_pclk; b_prst_n is asynchronous, active-low.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- b_pclk, in, 1, clock
- b_prst_n, in, 1, asynchronous active-low reset
- req_valid, in, NUM_REQ, per-requester transfer request
- req_ready, out, NUM_REQ, one-hot accept pulse
- req_write, in, NUM_REQ, per-requester direction (1 = write)
- req_addr, in, NUM_REQ*ADDR_WD, packed addresses; requester i at [i*ADDR_WD +: ADDR_WD]
- req_wdata, in, NUM_REQ*DATA_WD, packed write data
- req_prot, in, NUM_REQ*PROT_WD, packed pprot
- req_strb, in, NUM_REQ*STRB_WD, packed pstrb
- rsp_valid, out, NUM_REQ, one-hot completion pulse
- rsp_rdata, out, DATA_WD, read data for the completing requester
- rsp_err, out, 1, slave error or timeout, valid with rsp_valid
- b_psel, b_penable, b_pwrite, out, 1 each, APB control
- b_paddr, b_pwdata, b_pprot, b_pstrb, out, parameter widths, APB payload
- b_prdata, in, DATA_WD, APB read data
- b_pready, in, 1, APB ready
- b_pslverr, in, 1, APB slave error

Function
REQ-004 The FSM SHALL have three states: IDLE, SETUP, ACCESS. All APB outputs, req_ready, rsp_* SHALL be registered.
REQ-005 IDLE: when any req_valid is high, the arbiter SHALL select a winner round-robin, searching from last_grant+1 modulo NUM_REQ. It SHALL pulse req_ready[winner] for exactly one cycle, latch that requester's write/addr/wdata/prot/strb, update last_grant, and go to SETUP.
REQ-006 SETUP: b_psel=1, b_penable=0, payload stable; next state SHALL be ACCESS unconditionally.
REQ-007 ACCESS: b_psel=1, b_penable=1. On b_pready=1 the arbiter SHALL drop b_psel/b_penable next cycle, pulse rsp_valid[grant] for one cycle, set rsp_err=b_pslverr, and go to IDLE.
REQ-008 rsp_rdata SHALL equal the b_prdata captured at completion for reads, and all-zeros for writes or timeout; rsp_rdata holds its value until the next completion.
REQ-009 A timeout counter (width ceil(log2(TIMEOUT_CYC+1))) SHALL clear on SETUP entry and increment each ACCESS cycle with b_pready=0. When it reaches TIMEOUT_CYC with b_pready still 0, the arbiter SHALL abort: drop b_psel/b_penable, pulse rsp_valid[grant] with rsp_err=1 and rsp_rdata=0, and go to IDLE.
REQ-010 If b_pready=1 in the same cycle the count reaches TIMEOUT_CYC, normal completion SHALL take priority.
REQ-011 Minimum transfer period SHALL be 3 cycles (IDLE, SETUP, ACCESS); arbitration SHALL happen only in IDLE.
REQ-012 req_valid changes outside IDLE SHALL be ignored; a requester SHALL hold its payload until its req_ready pulse.
REQ-013 b_paddr, b_pwdata, b_pprot, b_pstrb, b_pwrite SHALL stay constant from SETUP through the final ACCESS cycle.
REQ-014 At most one bit of req_ready and of rsp_valid SHALL be set in any cycle.

Reset
REQ-015 On reset, state SHALL be IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), and the timeout counter 0. All outputs SHALL be 0, including payload and rsp_rdata.
REQ-016 A reset asserted mid-transfer SHALL force b_psel=b_penable=0 immediately, with no rsp_valid for the aborted transfer.

Verification
REQ-017 Single read: req_valid[2]=1, addr=0x40, b_pready=1 in first ACCESS, b_prdata=0xDEADBEEF -> req_ready[2] pulse; SETUP then ACCESS; rsp_valid[2] pulse with rsp_rdata=0xDEADBEEF and rsp_err=0.
REQ-018 Fairness: all four req_valid held high continuously after reset -> grant order 0,1,2,3,0, and each transfer takes 3 cycles with b_pready=1.
REQ-019 Wait states: write with b_pready low for 5 ACCESS cycles and b_pslverr=1 at completion -> payload stable for 6 ACCESS cycles; rsp_err=1 and rsp_rdata=0.
REQ-020 Timeout: TIMEOUT_CYC=4 and b_pready stuck at 0 -> abort after 4 ACCESS cycles with rsp_valid pulse and rsp_err=1; arbiter returns to IDLE and serves the next request.
REQ-021 Reset during ACCESS -> psel/penable go 0 asynchronously; after release, requester 0 has priority and no stale rsp_valid is produced.
